// File: rtl/core_io_buffer.sv
// Buffered bridge between the core's word-wide I/O port and a byte-serial UART datapath.
// RX bytes are packed into words and queued for core reads; core writes are queued and serialised.
module core_io_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int RX_DEPTH   = 16,
  parameter int TX_DEPTH   = 16,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          input_req,
  output logic [DATA_WIDTH-1:0]         input_data,
  output logic                          input_valid,
  input  logic [DATA_WIDTH-1:0]         output_data,
  input  logic                          output_valid,
  output logic                          io_stall,
  input  logic [7:0]                    rx_byte,
  input  logic                          rx_byte_valid,
  output logic [7:0]                    tx_byte,
  output logic                          tx_byte_valid,
  input  logic                          tx_byte_ready,
  output logic [$clog2(RX_DEPTH+1)-1:0] rx_count,
  output logic [$clog2(TX_DEPTH+1)-1:0] tx_count,
  output logic                          rx_overflow,
  output logic                          tx_overflow
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int RX_PW = $clog2(RX_DEPTH);
  localparam int TX_PW = $clog2(TX_DEPTH);
  localparam int RX_CW = $clog2(RX_DEPTH + 1);
  localparam int TX_CW = $clog2(TX_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [RX_CW-1:0] RX_FULL  = RX_CW'(RX_DEPTH);
  localparam logic [TX_CW-1:0] TX_FULL  = TX_CW'(TX_DEPTH);

  typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_WAIT = 1'b1} rd_state_t;

  // Wire order index k maps to a bit lane, mirrored for big-endian words.
  function automatic int lane_pos(input logic [IDX_W-1:0] k);
    return (BIG_ENDIAN != 0) ? (BYTES - 1 - int'(k)) : int'(k);
  endfunction

  function automatic logic [7:0] lane_get(input logic [DATA_WIDTH-1:0] w, input logic [IDX_W-1:0] k);
    return w[8*lane_pos(k) +: 8];
  endfunction

  logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
  logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];

  logic [RX_PW-1:0]      rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_CW-1:0]      rx_count_q, rx_count_d;
  logic [DATA_WIDTH-1:0] rx_word_q, rx_word_d;
  logic [IDX_W-1:0]      rx_idx_q, rx_idx_d;
  logic                  rx_overflow_q, rx_overflow_d;
  rd_state_t             rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] input_data_q, input_data_d;
  logic                  input_valid_q, input_valid_d;
  logic                  io_stall_q, io_stall_d;

  logic [TX_PW-1:0]      tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_CW-1:0]      tx_count_q, tx_count_d;
  logic [DATA_WIDTH-1:0] ser_word_q, ser_word_d;
  logic [IDX_W-1:0]      ser_idx_q, ser_idx_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_overflow_q, tx_overflow_d;

  logic rx_done_s, rx_push_s, rx_pop_s, tx_push_s, tx_pop_s, tx_xfer_s;

  // RX packing, read FSM and RX FIFO bookkeeping.
  always_comb begin
    rx_word_d     = rx_word_q;
    rx_idx_d      = rx_idx_q;
    rd_state_d    = rd_state_q;
    rx_pop_s      = 1'b0;
    rx_done_s     = 1'b0;
    if (rx_byte_valid) begin
      rx_word_d[8*lane_pos(rx_idx_q) +: 8] = rx_byte;
      if (rx_idx_q == LAST_IDX) begin
        rx_done_s = 1'b1;
        rx_idx_d  = IDX_W'(0);
      end else begin
        rx_idx_d  = rx_idx_q + IDX_W'(1);
      end
    end else begin
      rx_idx_d = rx_idx_q;
    end

    case (rd_state_q)
      RD_IDLE: begin
        if (input_req) begin
          if (rx_count_q != RX_CW'(0)) begin
            rx_pop_s = 1'b1;
          end else begin
            rd_state_d = RD_WAIT;
          end
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_WAIT: begin
        if (rx_count_q != RX_CW'(0)) begin
          rx_pop_s   = 1'b1;
          rd_state_d = RD_IDLE;
        end else begin
          rd_state_d = RD_WAIT;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    // A full FIFO still accepts the word if a pop frees a slot at the same edge.
    rx_push_s     = rx_done_s && ((rx_count_q != RX_FULL) || rx_pop_s);
    rx_overflow_d = rx_overflow_q || (rx_done_s && !rx_push_s);
    rx_wr_ptr_d   = rx_push_s ? rx_wr_ptr_q + RX_PW'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d   = rx_pop_s ? rx_rd_ptr_q + RX_PW'(1) : rx_rd_ptr_q;
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_count_d = rx_count_q + RX_CW'(1);
      2'b01:   rx_count_d = rx_count_q - RX_CW'(1);
      default: rx_count_d = rx_count_q;
    endcase
    input_valid_d = rx_pop_s;
    input_data_d  = rx_pop_s ? rx_mem[rx_rd_ptr_q] : input_data_q;
  end

  // TX FIFO and byte serialiser.
  always_comb begin
    ser_word_d = ser_word_q;
    ser_idx_d  = ser_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    tx_xfer_s  = tx_valid_q && tx_byte_ready;
    tx_pop_s   = (tx_count_q != TX_CW'(0)) &&
                 (!tx_valid_q || (tx_xfer_s && (ser_idx_q == LAST_IDX)));
    if (tx_pop_s) begin
      ser_word_d = tx_mem[tx_rd_ptr_q];
      ser_idx_d  = IDX_W'(0);
      tx_byte_d  = lane_get(tx_mem[tx_rd_ptr_q], IDX_W'(0));
      tx_valid_d = 1'b1;
    end else if (tx_xfer_s) begin
      if (ser_idx_q == LAST_IDX) begin
        tx_valid_d = 1'b0;
      end else begin
        ser_idx_d  = ser_idx_q + IDX_W'(1);
        tx_byte_d  = lane_get(ser_word_q, ser_idx_q + IDX_W'(1));
      end
    end else begin
      tx_valid_d = tx_valid_q;
    end

    tx_push_s     = output_valid && ((tx_count_q != TX_FULL) || tx_pop_s);
    tx_overflow_d = tx_overflow_q || (output_valid && !tx_push_s);
    tx_wr_ptr_d   = tx_push_s ? tx_wr_ptr_q + TX_PW'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d   = tx_pop_s ? tx_rd_ptr_q + TX_PW'(1) : tx_rd_ptr_q;
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
      2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
      default: tx_count_d = tx_count_q;
    endcase
    io_stall_d = (rd_state_d == RD_WAIT) || (tx_count_d == TX_FULL);
  end

  // FIFO storage; stale contents are harmless because occupancy is reset.
  always_ff @(posedge clk) begin
    if (rx_push_s) rx_mem[rx_wr_ptr_q] <= rx_word_d;
    if (tx_push_s) tx_mem[tx_wr_ptr_q] <= output_data;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      rx_count_q    <= '0;
      rx_word_q     <= '0;
      rx_idx_q      <= '0;
      rx_overflow_q <= 1'b0;
      rd_state_q    <= RD_IDLE;
      input_data_q  <= '0;
      input_valid_q <= 1'b0;
      io_stall_q    <= 1'b0;
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
      tx_count_q    <= '0;
      ser_word_q    <= '0;
      ser_idx_q     <= '0;
      tx_byte_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      rx_wr_ptr_q   <= rx_wr_ptr_d;
      rx_rd_ptr_q   <= rx_rd_ptr_d;
      rx_count_q    <= rx_count_d;
      rx_word_q     <= rx_word_d;
      rx_idx_q      <= rx_idx_d;
      rx_overflow_q <= rx_overflow_d;
      rd_state_q    <= rd_state_d;
      input_data_q  <= input_data_d;
      input_valid_q <= input_valid_d;
      io_stall_q    <= io_stall_d;
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
      tx_count_q    <= tx_count_d;
      ser_word_q    <= ser_word_d;
      ser_idx_q     <= ser_idx_d;
      tx_byte_q     <= tx_byte_d;
      tx_valid_q    <= tx_valid_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

  assign input_data    = input_data_q;
  assign input_valid   = input_valid_q;
  assign io_stall      = io_stall_q;
  assign tx_byte       = tx_byte_q;
  assign tx_byte_valid = tx_valid_q;
  assign rx_count      = rx_count_q;
  assign tx_count      = tx_count_q;
  assign rx_overflow   = rx_overflow_q;
  assign tx_overflow   = tx_overflow_q;

endmodule

// File: tb/tb_core_io_buffer.sv
// Bench for core_io_buffer: little- and big-endian instances share stimulus and are
// compared every cycle against a queue-based model of the FIFOs, read handshake and serialiser.
module tb_core_io_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, input_req, output_valid, rx_byte_valid, tx_byte_ready;
  logic [31:0] output_data;
  logic [7:0]  rx_byte;

  logic [31:0] le_input_data, be_input_data;
  logic        le_input_valid, be_input_valid, le_io_stall, be_io_stall;
  logic [7:0]  le_tx_byte, be_tx_byte;
  logic        le_tx_byte_valid, be_tx_byte_valid;
  logic [2:0]  le_rx_count, be_rx_count, le_tx_count, be_tx_count;
  logic        le_rx_overflow, be_rx_overflow, le_tx_overflow, be_tx_overflow;

  always #5 clk = ~clk;

  core_io_buffer #(.DATA_WIDTH(32), .RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH), .BIG_ENDIAN(0)) u_le (
    .clk(clk), .rst(rst), .input_req(input_req), .input_data(le_input_data),
    .input_valid(le_input_valid), .output_data(output_data), .output_valid(output_valid),
    .io_stall(le_io_stall), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .tx_byte(le_tx_byte), .tx_byte_valid(le_tx_byte_valid), .tx_byte_ready(tx_byte_ready),
    .rx_count(le_rx_count), .tx_count(le_tx_count), .rx_overflow(le_rx_overflow),
    .tx_overflow(le_tx_overflow));

  core_io_buffer #(.DATA_WIDTH(32), .RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH), .BIG_ENDIAN(1)) u_be (
    .clk(clk), .rst(rst), .input_req(input_req), .input_data(be_input_data),
    .input_valid(be_input_valid), .output_data(output_data), .output_valid(output_valid),
    .io_stall(be_io_stall), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .tx_byte(be_tx_byte), .tx_byte_valid(be_tx_byte_valid), .tx_byte_ready(tx_byte_ready),
    .rx_count(be_rx_count), .tx_count(be_tx_count), .rx_overflow(be_rx_overflow),
    .tx_overflow(be_tx_overflow));

  int unsigned pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

  // Reference model state
  logic [7:0]  m_bytes [4];
  int          m_bcnt = 0;
  logic [31:0] m_rxq [$];
  logic [31:0] m_txq [$];
  bit          m_wait = 1'b0, m_rx_ovf = 1'b0, m_tx_ovf = 1'b0, m_iv = 1'b0, m_pv = 1'b0;
  logic [31:0] m_last_rd = 32'h0, m_cur = 32'h0;
  int          m_ci = 0;
  logic [7:0]  m_tb_le = 8'h00, m_tb_be = 8'h00;

  function automatic logic [31:0] rev_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return 8'((w >> (8 * i)) & 32'hFF);
  endfunction

  function automatic bit m_stall();
    return m_wait || (m_txq.size() == DEPTH);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model from the inputs seen at that edge, compare all outputs.
  task automatic step();
    bit req_eff, pop_rx;
    int pre_tx;
    @(posedge clk);
    #1;
    if (rst) begin
      m_bcnt = 0; m_rxq.delete(); m_txq.delete();
      m_wait = 1'b0; m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; m_iv = 1'b0; m_pv = 1'b0;
      m_last_rd = 32'h0; m_ci = 0; m_tb_le = 8'h00; m_tb_be = 8'h00;
    end else begin
      req_eff = m_wait || input_req;
      pop_rx  = req_eff && (m_rxq.size() > 0);
      m_iv    = pop_rx;
      if (pop_rx) m_last_rd = m_rxq.pop_front();
      m_wait  = req_eff && !pop_rx;
      if (rx_byte_valid) begin
        m_bytes[m_bcnt] = rx_byte;
        m_bcnt++;
        if (m_bcnt == 4) begin
          m_bcnt = 0;
          if (m_rxq.size() < DEPTH) m_rxq.push_back({m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
          else m_rx_ovf = 1'b1;
        end
      end
      pre_tx = m_txq.size();
      if (!m_pv) begin
        if (pre_tx > 0) begin m_cur = m_txq.pop_front(); m_ci = 0; m_pv = 1'b1; end
      end else if (tx_byte_ready) begin
        if (m_ci == 3) begin
          if (pre_tx > 0) begin m_cur = m_txq.pop_front(); m_ci = 0; end
          else m_pv = 1'b0;
        end else begin
          m_ci++;
        end
      end
      if (output_valid) begin
        if (m_txq.size() < DEPTH) m_txq.push_back(output_data);
        else m_tx_ovf = 1'b1;
      end
      if (m_pv) begin
        m_tb_le = byte_of(m_cur, m_ci);
        m_tb_be = byte_of(m_cur, 3 - m_ci);
      end
    end
    check("input_valid", {31'h0, le_input_valid}, {31'h0, m_iv});
    check("input_data", le_input_data, m_last_rd);
    check("io_stall", {31'h0, le_io_stall}, {31'h0, m_stall()});
    check("rx_count", {29'h0, le_rx_count}, 32'(m_rxq.size()));
    check("tx_count", {29'h0, le_tx_count}, 32'(m_txq.size()));
    check("rx_overflow", {31'h0, le_rx_overflow}, {31'h0, m_rx_ovf});
    check("tx_overflow", {31'h0, le_tx_overflow}, {31'h0, m_tx_ovf});
    check("tx_byte_valid", {31'h0, le_tx_byte_valid}, {31'h0, m_pv});
    check("tx_byte", {24'h0, le_tx_byte}, {24'h0, m_tb_le});
    check("be_input_data", be_input_data, rev_bytes(m_last_rd));
    check("be_tx_byte", {24'h0, be_tx_byte}, {24'h0, m_tb_be});
    check("be_ctrl", {20'h0, be_input_valid, be_io_stall, be_tx_byte_valid, be_rx_count,
                      be_tx_count, be_rx_overflow, be_tx_overflow},
                     {20'h0, le_input_valid, le_io_stall, le_tx_byte_valid, le_rx_count,
                      le_tx_count, le_rx_overflow, le_tx_overflow});
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      rx_byte_valid = 1'b1;
      rx_byte       = byte_of(w, k);
      step();
    end
    rx_byte_valid = 1'b0;
  endtask

  task automatic read_word();
    input_req = 1'b1;
    step();
    input_req = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] w);
    output_valid = 1'b1;
    output_data  = w;
    step();
    output_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; input_req = 1'b0; output_valid = 1'b0; rx_byte_valid = 1'b0;
    tx_byte_ready = 1'b0; output_data = 32'h0; rx_byte = 8'h00;

    // Reset state
    step(); step();
    rst = 1'b0;
    step();

    // RX packing, both byte orders, and 1-cycle read latency
    send_word(32'h44332211);
    check("pack_count", {29'h0, le_rx_count}, 32'd1);
    read_word();
    check("pack_le", le_input_data, 32'h44332211);
    check("pack_be", be_input_data, 32'h11223344);
    check("pack_valid", {31'h0, le_input_valid}, 32'd1);
    step();

    // Read while empty: stall until the word lands
    read_word();
    check("wait_stall", {31'h0, le_io_stall}, 32'd1);
    step(); step();
    send_word($urandom);
    step();
    step();

    // RX overflow: five words into a four-deep FIFO
    for (int i = 0; i < 5; i++) send_word($urandom);
    check("ovf_count", {29'h0, le_rx_count}, 32'd4);
    check("ovf_flag", {31'h0, le_rx_overflow}, 32'd1);
    for (int i = 0; i < 4; i++) read_word();
    read_word();
    step(); step();
    send_word(32'hCAFEF00D);
    step();
    check("ovf_after", le_input_data, 32'hCAFEF00D);
    step();

    // TX with backpressure, then two words gapless
    write_word(32'hDEADBEEF);
    step();
    check("tx_first", {24'h0, le_tx_byte}, 32'h000000EF);
    step(); step();
    tx_byte_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    write_word($urandom);
    write_word($urandom);
    for (int i = 0; i < 10; i++) step();

    // TX full and overflow, drain, then wrap with many writes
    tx_byte_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word($urandom);
    check("txfull_stall", {31'h0, le_io_stall}, 32'd1);
    check("txfull_ovf", {31'h0, le_tx_overflow}, 32'd1);
    tx_byte_ready = 1'b1;
    for (int i = 0; i < 24; i++) step();
    for (int i = 0; i < 20; i++) begin
      tx_byte_ready = 1'($urandom_range(0, 1));
      if (!m_stall()) write_word($urandom);
      else step();
    end
    tx_byte_ready = 1'b1;
    for (int i = 0; i < 30; i++) step();

    // Reset mid-word
    write_word(32'h01020304);
    step(); step();
    rst = 1'b1;
    step();
    check("midrst_valid", {31'h0, le_tx_byte_valid}, 32'd0);
    rst = 1'b0;
    step();

    // Randomised mixed traffic
    for (int i = 0; i < 500; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      rx_byte_valid = 1'($urandom_range(0, 1));
      rx_byte       = 8'($urandom);
      input_req     = !m_stall() && ($urandom_range(0, 2) == 0);
      output_valid  = !m_stall() && ($urandom_range(0, 2) == 0);
      output_data   = $urandom;
      tx_byte_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0; rx_byte_valid = 1'b0; input_req = 1'b0; output_valid = 1'b0;
    tx_byte_ready = 1'b1;
    for (int i = 0; i < 30; i++) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
